// File: rtl/drive_cmd_arbiter.sv
// Three-requester motion command arbiter with coast dead-time on direction reversal.
// Define DRV_LEASE_EN to add the owner-lease auto-stop.
module drive_cmd_arbiter #(
    parameter int DEAD_CYC  = 4800,
    parameter int LEASE_CYC = 24000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       estop,
    input  logic [2:0] req_valid,
    input  logic [2:0] req_dir0,
    input  logic [2:0] req_dir1,
    input  logic [2:0] req_dir2,
    input  logic       req_spd0,
    input  logic       req_spd1,
    input  logic       req_spd2,
    output logic       mot_en,
    output logic [2:0] mot_dir,
    output logic       mot_spd,
    output logic [2:0] grant,
    output logic       busy
);
    localparam int DW = $clog2(DEAD_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [2:0]    cur_dir_reg, cur_dir_next;
    logic [2:0]    pend_dir_reg, pend_dir_next;
    logic          cur_spd_reg, cur_spd_next;
    logic          pend_spd_reg, pend_spd_next;
    logic [DW-1:0] dead_cnt_reg, dead_cnt_next;
    logic [2:0]    grant_next;

    logic [2:0]    sel_dir;
    logic          sel_spd;
    logic [2:0]    sel_onehot;
    logic          blocked;
    logic          accept;
    logic          lease_expire;

    // Only the lowest-index strobing requester is a candidate each cycle.
    always_comb begin
        sel_dir    = req_dir2;
        sel_spd    = req_spd2;
        sel_onehot = 3'b100;
        if (req_valid[0]) begin
            sel_dir    = req_dir0;
            sel_spd    = req_spd0;
            sel_onehot = 3'b001;
        end else if (req_valid[1]) begin
            sel_dir    = req_dir1;
            sel_spd    = req_spd1;
            sel_onehot = 3'b010;
        end
    end

    // A current owner of strictly higher priority locks the candidate out.
    assign blocked = |(grant & (sel_onehot - 3'd1));
    assign accept  = (|req_valid) && !estop && (sel_dir <= 3'd4) && !blocked;

`ifdef DRV_LEASE_EN
    localparam int LW = $clog2(LEASE_CYC);
    logic [LW-1:0] lease_cnt_reg;

    assign lease_expire = (grant != 3'd0) && (lease_cnt_reg == LW'(LEASE_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lease_cnt_reg <= '0;
        end else if (accept || grant_next == 3'd0) begin
            lease_cnt_reg <= '0;
        end else begin
            lease_cnt_reg <= lease_cnt_reg + 1'b1;
        end
    end
`else
    // Without a lease, ownership never times out.
    assign lease_expire = (LEASE_CYC < 0);
`endif

    always_comb begin
        state_next    = state_reg;
        cur_dir_next  = cur_dir_reg;
        cur_spd_next  = cur_spd_reg;
        pend_dir_next = pend_dir_reg;
        pend_spd_next = pend_spd_reg;
        dead_cnt_next = dead_cnt_reg;
        grant_next    = grant;

        if (estop || (accept && sel_dir == 3'd0) || (!accept && lease_expire)) begin
            state_next    = ST_IDLE;
            grant_next    = 3'd0;
            dead_cnt_next = '0;
        end else begin
            if (accept) begin
                grant_next = sel_onehot;
                case (state_reg)
                    ST_IDLE: begin
                        state_next   = ST_RUN;
                        cur_dir_next = sel_dir;
                        cur_spd_next = sel_spd;
                    end
                    ST_RUN: begin
                        if (sel_dir == cur_dir_reg) begin
                            cur_spd_next = sel_spd;
                        end else begin
                            state_next    = ST_DEAD;
                            pend_dir_next = sel_dir;
                            pend_spd_next = sel_spd;
                            dead_cnt_next = '0;
                        end
                    end
                    default: begin
                        pend_dir_next = sel_dir;
                        pend_spd_next = sel_spd;
                    end
                endcase
            end
            // The dead interval keeps running even while pending is being rewritten.
            if (state_reg == ST_DEAD) begin
                if (dead_cnt_reg == DW'(DEAD_CYC - 1)) begin
                    state_next    = ST_RUN;
                    cur_dir_next  = pend_dir_next;
                    cur_spd_next  = pend_spd_next;
                    dead_cnt_next = '0;
                end else begin
                    dead_cnt_next = dead_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cur_dir_reg  <= 3'd0;
            cur_spd_reg  <= 1'b0;
            pend_dir_reg <= 3'd0;
            pend_spd_reg <= 1'b0;
            dead_cnt_reg <= '0;
            grant        <= 3'd0;
            mot_en       <= 1'b0;
            mot_dir      <= 3'd0;
            mot_spd      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cur_dir_reg  <= cur_dir_next;
            cur_spd_reg  <= cur_spd_next;
            pend_dir_reg <= pend_dir_next;
            pend_spd_reg <= pend_spd_next;
            dead_cnt_reg <= dead_cnt_next;
            grant        <= grant_next;
            mot_en       <= (state_next == ST_RUN);
            mot_dir      <= (state_next == ST_RUN) ? cur_dir_next : 3'd0;
            mot_spd      <= (state_next == ST_RUN) && cur_spd_next;
            busy         <= (state_next == ST_DEAD);
        end
    end

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Scoreboard bench for drive_cmd_arbiter: timestamp-based reference model feeds an expected queue
// that a free-running monitor drains once per clock.
module tb_drive_cmd_arbiter;
    localparam int DEAD  = 8;
    localparam int LEASE = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       estop = 1'b0;
    logic [2:0] req_valid = 3'd0;
    logic [2:0] req_dir0 = 3'd0, req_dir1 = 3'd0, req_dir2 = 3'd0;
    logic       req_spd0 = 1'b0, req_spd1 = 1'b0, req_spd2 = 1'b0;
    logic       mot_en;
    logic [2:0] mot_dir;
    logic       mot_spd;
    logic [2:0] grant;
    logic       busy;

    always #5 clk = ~clk;

    drive_cmd_arbiter #(.DEAD_CYC(DEAD), .LEASE_CYC(LEASE)) dut (
        .clk(clk), .rst_n(rst_n), .estop(estop), .req_valid(req_valid),
        .req_dir0(req_dir0), .req_dir1(req_dir1), .req_dir2(req_dir2),
        .req_spd0(req_spd0), .req_spd1(req_spd1), .req_spd2(req_spd2),
        .mot_en(mot_en), .mot_dir(mot_dir), .mot_spd(mot_spd), .grant(grant), .busy(busy)
    );

    typedef struct packed {
        logic       en;
        logic [2:0] dir;
        logic       spd;
        logic [2:0] gnt;
        logic       bsy;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Reference model: mode plus absolute edge timestamps for refresh and dead-time start.
    typedef enum int {M_IDLE, M_RUN, M_DEAD} mmode_t;
    mmode_t m_mode = M_IDLE;
    int m_owner = -1;
    int m_dir = 0, m_spd = 0, m_pdir = 0, m_pspd = 0;
    int m_now = 0, m_refresh = 0, m_dead_start = 0;

    function automatic bit lease_timeout();
`ifdef DRV_LEASE_EN
        return (m_owner >= 0) && (m_now - m_refresh == LEASE);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_owner = -1;
    endtask

    task automatic model_step(input logic [2:0] v, input logic [2:0] d0, input logic [2:0] d1,
                              input logic [2:0] d2, input logic [2:0] s, input logic e);
        int dirs[3];
        int cand;
        bit acc;
        mmode_t was;
        dirs[0] = int'(d0);
        dirs[1] = int'(d1);
        dirs[2] = int'(d2);
        m_now++;
        was  = m_mode;
        cand = -1;
        for (int i = 2; i >= 0; i--) if (v[i]) cand = i;
        acc = 1'b0;
        if (!e && cand >= 0)
            acc = (dirs[cand] <= 4) && (m_owner < 0 || m_owner >= cand);
        if (e || (acc && dirs[cand] == 0) || (!acc && lease_timeout())) begin
            m_mode  = M_IDLE;
            m_owner = -1;
        end else begin
            if (acc) begin
                m_owner   = cand;
                m_refresh = m_now;
                if (m_mode == M_IDLE) begin
                    m_mode = M_RUN;
                    m_dir  = dirs[cand];
                    m_spd  = int'(s[cand]);
                end else if (m_mode == M_RUN && dirs[cand] == m_dir) begin
                    m_spd = int'(s[cand]);
                end else begin
                    if (m_mode == M_RUN) m_dead_start = m_now;
                    m_mode = M_DEAD;
                    m_pdir = dirs[cand];
                    m_pspd = int'(s[cand]);
                end
            end
            if (was == M_DEAD && m_now - m_dead_start == DEAD) begin
                m_mode = M_RUN;
                m_dir  = m_pdir;
                m_spd  = m_pspd;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.en  = (m_mode == M_RUN);
        x.dir = (m_mode == M_RUN) ? 3'(m_dir) : 3'd0;
        x.spd = (m_mode == M_RUN) ? 1'(m_spd) : 1'b0;
        x.gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'd0;
        x.bsy = (m_mode == M_DEAD);
        return x;
    endfunction

    task automatic drive(input logic [2:0] v, input logic [2:0] d0, input logic [2:0] d1,
                         input logic [2:0] d2, input logic [2:0] s, input logic e);
        @(negedge clk);
        req_valid = v;
        req_dir0  = d0;
        req_dir1  = d1;
        req_dir2  = d2;
        {req_spd2, req_spd1, req_spd0} = s;
        estop = e;
        model_step(v, d0, d1, d2, s, e);
        exp_q.push_back(model_out());
        if (v != 3'd0 || e)
            $display("txn t=%0t valid=%b dir=%0d/%0d/%0d spd=%b estop=%b", $time, v, d0, d1, d2, s, e);
    endtask

    task automatic cmd(input int i, input logic [2:0] d, input logic sp, input logic e);
        logic [2:0] dd[3];
        logic [2:0] v;
        logic [2:0] s;
        dd[0] = 3'd0; dd[1] = 3'd0; dd[2] = 3'd0;
        dd[i] = d;
        v = 3'b001 << i;
        s = {2'b00, sp} << i;
        drive(v, dd[0], dd[1], dd[2], s, e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        total++;
        if ({mot_en, mot_dir, mot_spd, grant, busy} !== 9'd0) begin
            bad++;
            $display("FAIL %s: got en=%b dir=%0d spd=%b grant=%b busy=%b, expected all zero",
                     tag, mot_en, mot_dir, mot_spd, grant, busy);
        end
    endtask

    // Asynchronous reset pulse: outputs must clear without waiting for a clock edge.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        estop = 1'b0;
        req_valid = 3'd0;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && exp_q.size() > 0) begin
                x = exp_q.pop_front();
                total++;
                if ({mot_en, mot_dir, mot_spd, grant, busy} !== x) begin
                    bad++;
                    $display("FAIL outputs t=%0t: got en=%b dir=%0d spd=%b grant=%b busy=%b, expected en=%b dir=%0d spd=%b grant=%b busy=%b",
                             $time, mot_en, mot_dir, mot_spd, grant, busy, x.en, x.dir, x.spd, x.gnt, x.bsy);
                end
            end
        end
    end

    initial begin : stimulus
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        @(posedge clk);
        #3;
        check_zero("reset_hold");
        rst_n = 1'b1;

        // Remote forward full, then reversal through dead time.
        cmd(1, 3'd1, 1'b1, 1'b0);
        idle(2);
        cmd(1, 3'd2, 1'b0, 1'b0);
        idle(12);
        // Reversal with a left command landing inside the dead window.
        cmd(1, 3'd1, 1'b1, 1'b0);
        idle(2);
        cmd(1, 3'd2, 1'b1, 1'b0);
        idle(2);
        cmd(1, 3'd3, 1'b0, 1'b0);
        idle(12);
        cmd(1, 3'd0, 1'b0, 1'b0);

        // Priority: manual beats auto, auto ignored while manual owns, accepted after manual stop.
        drive(3'b101, 3'd1, 3'd0, 3'd2, 3'b101, 1'b0);
        idle(2);
        cmd(2, 3'd2, 1'b1, 1'b0);
        idle(2);
        cmd(0, 3'd0, 1'b0, 1'b0);
        cmd(2, 3'd2, 1'b1, 1'b0);

        // Lease expiry, then refresh just before the deadline.
        idle(110);
        cmd(2, 3'd1, 1'b1, 1'b0);
        idle(98);
        cmd(2, 3'd1, 1'b0, 1'b0);
        idle(60);
        idle(50);

        // estop during dead time with a simultaneous command, then release.
        cmd(0, 3'd1, 1'b1, 1'b0);
        idle(2);
        cmd(0, 3'd2, 1'b1, 1'b0);
        idle(3);
        cmd(0, 3'd3, 1'b1, 1'b1);
        cmd(1, 3'd1, 1'b1, 1'b1);
        drive(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
        idle(3);
        cmd(0, 3'd1, 1'b0, 1'b0);
        cmd(0, 3'd0, 1'b0, 1'b0);

        // Invalid direction code in idle, then async reset mid-dead.
        cmd(0, 3'd6, 1'b1, 1'b0);
        idle(2);
        cmd(1, 3'd1, 1'b1, 1'b0);
        idle(1);
        cmd(1, 3'd4, 1'b1, 1'b0);
        idle(3);
        reset_pulse("reset_mid_dead");
        idle(3);

        // Randomized traffic with occasional estop bursts and long silences.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] v;
            v[0] = ($urandom_range(0, 11) == 0);
            v[1] = ($urandom_range(0, 11) == 0);
            v[2] = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 199) == 0) begin
                repeat ($urandom_range(1, 4))
                    drive(v, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 3'($urandom), 1'b1);
            end else begin
                drive(v, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 3'($urandom), 1'b0);
            end
            if (n % 600 == 599) idle(LEASE + 5);
            if (n == 1500) reset_pulse("reset_random");
        end
        idle(2);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
